// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial 64-bit adder controller.
//   - state encoding for the controller FSM
//   - default operand width and slice width
//   - slice count derivation (DATA_W must be a multiple of SLICE_W)
package serial_add_ctrl_pkg;

  localparam int DATA_W_DEF  = 64;
  localparam int SLICE_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nslice(input int data_w, input int slice_w);
    return data_w / slice_w;
  endfunction

  localparam int NSLICE_DEF = nslice(DATA_W_DEF, SLICE_W_DEF);

endpackage

// File: rtl/serial_add_ctrl_add_slice.sv
// add_slice: combinational W-bit ripple-carry adder built from full adders.
// Ports:
//   a, b   [W-1:0] addends
//   c_in           carry into bit 0
//   sum    [W-1:0] a + b + c_in (low W bits)
//   c_out          carry out of bit W-1
module add_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  logic [W:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
  end

  assign c_out = c[W];

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: multi-cycle DATA_W adder that reuses one SLICE_W-bit
// ripple slice, LSB slice first, with the carry held in a register.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed overflow output.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, c_in)
//   out_valid/out_ready result handshake (sum, c_out[, ovf])
//   busy                high while an operation is in RUN or DONE
//   ovf                 signed overflow (SERIAL_ADD_OVF_EN only)
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              c_out,
  output logic              busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int NSLICE = nslice(DATA_W, SLICE_W);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } opnd_t;

  state_e             state, state_nxt;
  opnd_t              op_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  work_q, work_nxt;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_co;
  logic               last;
  logic               accept;

  // Single shared slice; the operand field is chosen by idx_q.
  assign sl_a = op_q.a[int'(idx_q)*SLICE_W +: SLICE_W];
  assign sl_b = op_q.b[int'(idx_q)*SLICE_W +: SLICE_W];

  add_slice #(.W(SLICE_W)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .c_in (carry_q),
    .sum  (sl_sum),
    .c_out(sl_co)
  );

  // Working sum with the current slice merged in; used both to update the
  // working register and to load the output register on the last slice.
  always_comb begin
    work_nxt = work_q;
    work_nxt[int'(idx_q)*SLICE_W +: SLICE_W] = sl_sum;
  end

  assign last   = (idx_q == IDX_W'(NSLICE - 1));
  assign accept = in_valid & in_ready;

  // Outputs decode from state only; rst just masks ready during the reset cycle.
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q.a  <= a;
            op_q.b  <= b;
            carry_q <= c_in;
            idx_q   <= '0;
          end
        end
        RUN: begin
          work_q  <= work_nxt;
          carry_q <= sl_co;
          idx_q   <= last ? '0 : idx_q + 1'b1;
          if (last) begin
            sum   <= work_nxt;
            c_out <= sl_co;
`ifdef SERIAL_ADD_OVF_EN
            // Same-sign operands producing an opposite-sign result.
            ovf   <= (op_q.a[DATA_W-1] == op_q.b[DATA_W-1]) &&
                     (work_nxt[DATA_W-1] != op_q.a[DATA_W-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: scoreboard of expected results
// pushed at operand acceptance and compared at result presentation.
module tb_serial_add_ctrl;

  localparam int NSL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        c_in = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic        in_ready, out_valid, c_out, busy, ovf;
  logic [63:0] sum;

  serial_add_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic [64:0] f;
    exp_t e;
    f   = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    e.s = f[63:0];
    e.c = f[64];
    e.v = (x[63] == y[63]) && (f[63] != x[63]);
    return e;
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) sb_q.delete();
    else begin
      if (in_valid && in_ready) sb_q.push_back(model(a, b, c_in));
      if (out_valid) begin
        if (sb_q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          e = sb_q[0];
          chk("sum", sum, e.s);
          chk("c_out", c_out, e.c);
`ifdef SERIAL_ADD_OVF_EN
          chk("ovf", ovf, e.v);
`endif
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  // Drive operands until accepted; returns #1 after the acceptance edge.
  task automatic send(input logic [63:0] xa, input logic [63:0] xb, input logic xc);
    int  n;
    logic rdy;
    in_valid = 1'b1; a = xa; b = xb; c_in = xc;
    n = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  // Full operation with out_ready high, checking latency.
  task automatic run_op(input string tag, input logic [63:0] xa, input logic [63:0] xb, input logic xc);
    int n;
    out_ready = 1'b1;
    send(xa, xb, xc);
    wait_out(n);
    chk({tag, "_latency"}, n, NSL);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [63:0] ra, rb;
    logic        rc, hs;
    exp_t        e;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Simple add; out_valid is a single-cycle pulse with out_ready high
    out_ready = 1'b1;
    send(64'h1, 64'h1, 1'b0);
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    wait_out(n);
    chk("lat_first", n, NSL);
    @(posedge clk); #1;
    chk("ov_pulse", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("hold_sum_after_hs", sum, 64'h2);

    // Carry through all slices and complementary patterns
    run_op("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op("pat1", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
    run_op("pat2", 64'h1234_5678_9ABC_DEF0, 64'hEDCB_A987_6543_210F, 1'b1);

    // Backpressure with new operands pending
    out_ready = 1'b0;
    send(64'hDEAD_BEEF_0000_1111, 64'h2222_0000_FFFF_FFFF, 1'b1);
    wait_out(n);
    chk("bp_latency", n, NSL);
    e = model(64'hDEAD_BEEF_0000_1111, 64'h2222_0000_FFFF_FFFF, 1'b1);
    in_valid = 1'b1; a = 64'h0000_0000_0000_0AAA; b = 64'h0000_0000_0000_0555; c_in = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, e.s);
      chk("bp_c_out", c_out, e.c);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    send(64'h0000_0000_0000_0AAA, 64'h0000_0000_0000_0555, 1'b1);
    wait_out(n);
    chk("bp_next_latency", n, NSL);
    @(posedge clk); #1;

    // Reset in the middle of RUN, at idx 2
    send(64'h5, 64'h6, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_c_out", c_out, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_rdy", in_ready, 1);
    hs = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      hs = hs | out_valid;
    end
    chk("mid_rst_no_out", hs, 0);
    run_op("after_rst", 64'h3, 64'h4, 1'b1);

`ifdef SERIAL_ADD_OVF_EN
    run_op("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
`endif

    // Random operands with random result backpressure
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if (i == 0) rb = ~ra;
      out_ready = 1'b0;
      send(ra, rb, rc);
      n = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk); hs = out_valid && out_ready;
        @(posedge clk); #1;
        n++;
      end while (!hs && n < 100);
      if (!hs) chk("rand_hs_timeout", 0, 1);
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
